// File: rtl/noc_inj_pkg.sv
// rtl/noc_inj_pkg.sv - shared types, display constants and hex segment decoder
package noc_inj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } inj_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// rtl/noc_packet_injector_if.sv - flat per-router packet bus with per-router ready
interface noc_packet_injector_if #(
    parameter int N_ROUTERS = 49,
    parameter int PKT_W     = 13
);
    logic [N_ROUTERS-1:0]       in_ready;
    logic [N_ROUTERS*PKT_W-1:0] out_routers;

    modport master (output out_routers, input in_ready);
    modport slave  (input out_routers, output in_ready);
endinterface

// File: rtl/key_edge.sv
// rtl/key_edge.sv - 2-flop synchroniser plus registered rising-edge pulse for a raw key
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_pulse
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic pulse_q, pulse_d;

    always_comb begin
        s1_d    = key_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        pulse_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pulse_q <= pulse_d;
        end
    end

    assign key_level = s2_q;
    assign key_pulse = pulse_q;
endmodule

// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - switch/key driven packet source for the router array
module noc_packet_injector
    import noc_inj_pkg::*;
#(
    parameter int N_ROUTERS = 49,
    parameter int DATA_W    = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_on,
    input  logic                   sw_mode,
    input  logic                   sw_sel_data,
    input  logic                   sw_sel_router,
    input  logic                   key_inc,
    input  logic                   key_dec,
    input  logic                   key_send,
    noc_packet_injector_if.master  bus,
    output logic [15:0]            sent_cnt,
    output logic [6:0]             hex_data1,
    output logic [6:0]             hex_data0,
    output logic [6:0]             hex_router1,
    output logic [6:0]             hex_router0
);
    localparam int ROUTER_W = $clog2(N_ROUTERS);
    localparam int PKT_W    = DATA_W + 1;
    localparam int BUS_W    = N_ROUTERS * PKT_W;
    localparam logic [ROUTER_W-1:0] ROUTER_LAST = ROUTER_W'(N_ROUTERS - 1);

    logic inc_p, dec_p, send_p, send_lvl;
    logic unused_inc_lvl, unused_dec_lvl;

    key_edge u_key_inc  (.clk(clk), .rst_n(rst_n), .key_in(key_inc),
                         .key_level(unused_inc_lvl), .key_pulse(inc_p));
    key_edge u_key_dec  (.clk(clk), .rst_n(rst_n), .key_in(key_dec),
                         .key_level(unused_dec_lvl), .key_pulse(dec_p));
    key_edge u_key_send (.clk(clk), .rst_n(rst_n), .key_in(key_send),
                         .key_level(send_lvl), .key_pulse(send_p));

    inj_state_e           state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d, lat_data_q, lat_data_d;
    logic [ROUTER_W-1:0]  router_q, router_d, lat_router_q, lat_router_d;
    logic [BUS_W-1:0]     out_q, out_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [6:0]           hd1_q, hd1_d, hd0_q, hd0_d, hr1_q, hr1_d, hr0_q, hr0_d;

    // Register editing; simultaneous inc/dec cancel, SEND/DONE lock the values
    always_comb begin
        logic step_up, step_dn;
        step_up  = inc_p & ~dec_p;
        step_dn  = dec_p & ~inc_p;
        data_d   = data_q;
        router_d = router_q;
        if (state_q == IDLE || state_q == HOLD) begin
            if (sw_sel_data) begin
                if (step_up)      data_d = data_q + 1'b1;
                else if (step_dn) data_d = data_q - 1'b1;
            end else if (sw_sel_router) begin
                if (step_up)      router_d = (router_q == ROUTER_LAST) ? '0 : router_q + 1'b1;
                else if (step_dn) router_d = (router_q == '0) ? ROUTER_LAST : router_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_data_d   = lat_data_q;
        lat_router_d = lat_router_q;
        cnt_d        = cnt_q;
        out_d        = '0;
        case (state_q)
            IDLE: begin
                if (sw_on && !sw_mode) begin
                    state_d = HOLD;
                end else if (sw_on && sw_mode && send_p) begin
                    state_d      = SEND;
                    lat_data_d   = data_q;
                    lat_router_d = router_q;
                end
            end
            HOLD: if (!sw_on || sw_mode) state_d = IDLE;
            SEND: begin
                if (!sw_on) begin
                    state_d = IDLE;
                end else if (bus.in_ready[lat_router_q]) begin
                    state_d = DONE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            DONE: if (!send_lvl) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Placement follows the next state so the packet is visible on SEND entry
        // and drops on the same edge that accepts it
        if (state_d == HOLD)
            out_d[int'(router_q) * PKT_W +: PKT_W] = {1'b1, data_q};
        else if (state_d == SEND)
            out_d[int'(lat_router_d) * PKT_W +: PKT_W] = {1'b1, lat_data_d};
    end

    always_comb begin
        logic [7:0] data8, router8;
        data8   = 8'(data_q);
        router8 = 8'(router_q);
        hd1_d   = seg7_hex(data8[7:4]);
        hd0_d   = seg7_hex(data8[3:0]);
        hr1_d   = seg7_hex(router8[7:4]);
        hr0_d   = seg7_hex(router8[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            router_q     <= '0;
            lat_data_q   <= '0;
            lat_router_q <= '0;
            out_q        <= '0;
            cnt_q        <= '0;
            hd1_q        <= SEG_ZERO;
            hd0_q        <= SEG_ZERO;
            hr1_q        <= SEG_ZERO;
            hr0_q        <= SEG_ZERO;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            router_q     <= router_d;
            lat_data_q   <= lat_data_d;
            lat_router_q <= lat_router_d;
            out_q        <= out_d;
            cnt_q        <= cnt_d;
            hd1_q        <= hd1_d;
            hd0_q        <= hd0_d;
            hr1_q        <= hr1_d;
            hr0_q        <= hr0_d;
        end
    end

    assign bus.out_routers = out_q;
    assign sent_cnt        = cnt_q;
    assign hex_data1       = hd1_q;
    assign hex_data0       = hd0_q;
    assign hex_router1     = hr1_q;
    assign hex_router0     = hr0_q;
endmodule
